// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (instruction/data) arbiter in front of a single RAM
//
// Purpose:
//   Serialises instruction fetches and data reads/writes onto one RAM port.
//   Data requests win by default. An instruction fetch that has been waiting
//   through STARVE_MAX data grants gets the next grant. Every access is
//   bounded by TIMEOUT wait cycles. A RAM error, a timeout, or a read+write
//   data request sets the sticky memerr flag.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   iREN, iaddr         instruction read request (held until ihit) and address
//   dREN, dWEN          data read/write request (held until dhit)
//   daddr, dstore       data address and write value
//   ramload, ramstate   RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   ihit, iload         instruction completion pulse and fetched word
//   dhit, dload         data completion pulse and loaded word
//   ramREN, ramWEN      RAM read/write strobes
//   ramaddr, ramstore   RAM address and write data
//   memerr              sticky error flag

module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        memerr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [3:0] WAIT_LIM   = 4'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic        wr_q, wr_d;        // latched access type of the data grant
    logic        is_data_q, is_data_d; // which port DONE reports to
    logic [31:0] iload_q, iload_d;
    logic [31:0] dload_q, dload_d;
    logic        memerr_q, memerr_d;
    logic [2:0]  starve_q, starve_d;
    logic [3:0]  wait_q, wait_d;

    logic        data_req;
    logic        grant_instr;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        store_d   = store_q;
        wr_d      = wr_q;
        is_data_d = is_data_q;
        iload_d   = iload_q;
        dload_d   = dload_q;
        memerr_d  = memerr_q;
        starve_d  = starve_q;
        wait_d    = wait_q;

        data_req    = dREN | dWEN;
        // The starved fetch overrides a pending data request; otherwise a
        // fetch is only granted when the data port is quiet.
        grant_instr = iREN && (!data_req || (starve_q == STARVE_LIM));

        case (state_q)
            IDLE: begin
                if (!iREN) begin
                    starve_d = 3'd0;
                end
                if (grant_instr) begin
                    state_d   = IACC;
                    addr_d    = iaddr;
                    wr_d      = 1'b0;
                    is_data_d = 1'b0;
                    wait_d    = 4'd0;
                    starve_d  = 3'd0;
                end else if (data_req) begin
                    state_d   = DACC;
                    addr_d    = daddr;
                    store_d   = dstore;
                    // A simultaneous read+write is resolved as a write and
                    // flagged as an error.
                    wr_d      = dWEN;
                    is_data_d = 1'b1;
                    wait_d    = 4'd0;
                    if (dREN && dWEN) begin
                        memerr_d = 1'b1;
                    end
                    if (iREN && (starve_q < STARVE_LIM)) begin
                        starve_d = starve_q + 3'd1;
                    end
                end
            end

            IACC, DACC: begin
                if (ramstate == RAM_ACCESS) begin
                    if (state_q == DACC) begin
                        dload_d = ramload;
                    end else begin
                        iload_d = ramload;
                    end
                    state_d = DONE;
                end else if (ramstate == RAM_ERROR) begin
                    // Abort without a hit; the requester still holds its
                    // request, so it is simply retried from IDLE.
                    memerr_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    wait_d = wait_q + 4'd1;
                    if ((wait_q + 4'd1) == WAIT_LIM) begin
                        memerr_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end

            DONE: begin
                // Requests are deliberately not sampled here so a request
                // still held during its own hit cycle is not granted twice.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            addr_q    <= 32'd0;
            store_q   <= 32'd0;
            wr_q      <= 1'b0;
            is_data_q <= 1'b0;
            iload_q   <= 32'd0;
            dload_q   <= 32'd0;
            memerr_q  <= 1'b0;
            starve_q  <= 3'd0;
            wait_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            wr_q      <= wr_d;
            is_data_q <= is_data_d;
            iload_q   <= iload_d;
            dload_q   <= dload_d;
            memerr_q  <= memerr_d;
            starve_q  <= starve_d;
            wait_q    <= wait_d;
        end
    end

    // RAM side is driven purely from state and latched request fields.
    assign ramREN   = (state_q == IACC) || ((state_q == DACC) && !wr_q);
    assign ramWEN   = (state_q == DACC) && wr_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

    assign ihit   = (state_q == DONE) && !is_data_q;
    assign dhit   = (state_q == DONE) && is_data_q;
    assign iload  = iload_q;
    assign dload  = dload_q;
    assign memerr = memerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter

module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        memerr;

    mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(15)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ihit     (ihit),
        .iload    (iload),
        .dhit     (dhit),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .memerr   (memerr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_write;
        logic [31:0] data;
    } dexp_t;

    logic [31:0] iq[$];
    dexp_t       dq[$];
    logic [63:0] wq[$];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] ram_mem[logic [31:0]];

    int          n_pass = 0;
    int          n_total = 0;
    bit          force_mode = 1'b1;
    int          lat_left = -1;
    logic [63:0] w_ent;
    logic [31:0] i_ent;
    dexp_t       d_ent;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // RAM device: random BUSY latency, then ACCESS; records writes.
    initial begin
        forever begin
            @(negedge CLK);
            if (!force_mode) begin
                if (ramREN || ramWEN) begin
                    if (lat_left < 0) lat_left = int'($urandom_range(0, 4));
                    if (lat_left > 0) begin
                        ramstate = 2'd1;
                        lat_left--;
                    end else begin
                        ramstate = 2'd2;
                        lat_left = -1;
                        if (ramWEN) begin
                            if (wq.size() == 0) begin
                                chk1("spurious_write", ramWEN, 1'b0);
                            end else begin
                                w_ent = wq.pop_front();
                                chk("write_addr", ramaddr, w_ent[63:32]);
                                chk("write_data", ramstore, w_ent[31:0]);
                            end
                            ram_mem[ramaddr] = ramstore;
                            ramload = $urandom;
                        end else begin
                            ramload = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : init_word(ramaddr);
                        end
                    end
                end else begin
                    ramstate = 2'd0;
                    lat_left = -1;
                    ramload  = $urandom;
                end
            end else begin
                lat_left = -1;
            end
        end
    end

    // Monitor: every hit pops the oldest expectation of its port.
    initial begin
        forever begin
            @(negedge CLK);
            if (ihit) begin
                if (iq.size() == 0) begin
                    chk1("spurious_ihit", ihit, 1'b0);
                end else begin
                    i_ent = iq.pop_front();
                    chk("iload", iload, i_ent);
                end
            end
            if (dhit) begin
                if (dq.size() == 0) begin
                    chk1("spurious_dhit", dhit, 1'b0);
                end else begin
                    d_ent = dq.pop_front();
                    if (!d_ent.is_write) chk("dload", dload, d_ent.data);
                end
            end
        end
    end

    initial begin
        int          hits;
        int          busy_cycles;
        logic [5:0]  order;
        logic [31:0] a;

        RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
        repeat (2) @(negedge CLK);
        chk1("rst_ramREN", ramREN, 1'b0);
        chk1("rst_ramWEN", ramWEN, 1'b0);
        chk1("rst_hits", ihit | dhit, 1'b0);
        chk1("rst_memerr", memerr, 1'b0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        RST = 1'b0;

        // Minimum-latency instruction fetch
        iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd2; ramload = 32'h8C010004;
        iq.push_back(32'h8C010004);
        @(negedge CLK);
        chk1("t27_ramREN_c1", ramREN, 1'b1);
        chk("t27_ramaddr", ramaddr, 32'h40);
        chk1("t27_ihit_c1", ihit, 1'b0);
        @(negedge CLK);
        chk1("t27_ihit_c2", ihit, 1'b1);
        chk("t27_iload_c2", iload, 32'h8C010004);
        chk1("t27_ramREN_c2", ramREN, 1'b0);
        iREN = 1'b0;
        @(negedge CLK);
        chk1("t27_ihit_c3", ihit, 1'b0);

        // Data write and instruction fetch together: data first
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        ramload = 32'h11111111;
        dq.push_back(dexp_t'{is_write: 1'b1, data: 32'd0});
        iq.push_back(32'h11111111);
        @(negedge CLK);
        chk1("t28_ramWEN", ramWEN, 1'b1);
        chk1("t28_ramREN", ramREN, 1'b0);
        chk("t28_ramaddr", ramaddr, 32'h100);
        chk("t28_ramstore", ramstore, 32'hDEADBEEF);
        @(negedge CLK);
        chk1("t28_dhit", dhit, 1'b1);
        dWEN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk1("t28_iacc_ramREN", ramREN, 1'b1);
        chk("t28_iacc_ramaddr", ramaddr, 32'h44);
        @(negedge CLK);
        chk1("t28_ihit", ihit, 1'b1);
        chk1("t28_memerr", memerr, 1'b0);
        iREN = 1'b0;
        @(negedge CLK);

        // Continuous contention: D,D,D,D,I,D
        iREN = 1'b1; iaddr = 32'h48; dREN = 1'b1; daddr = 32'h104; ramload = 32'h22222222;
        for (int k = 0; k < 5; k++) dq.push_back(dexp_t'{is_write: 1'b0, data: 32'h22222222});
        iq.push_back(32'h22222222);
        hits = 0; order = '0;
        for (int c = 0; c < 60 && hits < 6; c++) begin
            @(negedge CLK);
            if (dhit) begin order = {order[4:0], 1'b1}; hits++; end
            else if (ihit) begin order = {order[4:0], 1'b0}; hits++; end
        end
        iREN = 1'b0; dREN = 1'b0;
        chk("t29_hits", 32'(hits), 32'd6);
        chk("t29_order", {26'd0, order}, 32'b111101);

        // Timeout after 15 BUSY cycles
        @(negedge CLK);
        chk1("t30_memerr_before", memerr, 1'b0);
        dREN = 1'b1; daddr = 32'h200; ramstate = 2'd1;
        busy_cycles = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge CLK);
            if (ramREN) busy_cycles++;
        end
        chk("t30_busy_cycles", 32'(busy_cycles), 32'd15);
        @(negedge CLK);
        chk1("t30_idle_ramREN", ramREN, 1'b0);
        chk1("t30_memerr", memerr, 1'b1);
        chk1("t30_no_dhit", dhit, 1'b0);
        dREN = 1'b0; ramstate = 2'd0;
        repeat (3) @(negedge CLK);
        chk1("t30_memerr_sticky", memerr, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        chk1("t30_memerr_rst", memerr, 1'b0);
        RST = 1'b0;

        // ERROR then retry
        dREN = 1'b1; daddr = 32'h300; ramstate = 2'd1;
        dq.push_back(dexp_t'{is_write: 1'b0, data: 32'h33333333});
        @(negedge CLK);
        chk1("t31_ramREN", ramREN, 1'b1);
        ramstate = 2'd3;
        @(negedge CLK);
        chk1("t31_memerr", memerr, 1'b1);
        chk1("t31_abort_ramREN", ramREN, 1'b0);
        chk1("t31_no_dhit", dhit, 1'b0);
        ramstate = 2'd2; ramload = 32'h33333333;
        @(negedge CLK);
        chk1("t31_retry_ramREN", ramREN, 1'b1);
        @(negedge CLK);
        chk1("t31_dhit", dhit, 1'b1);
        chk("t31_dload", dload, 32'h33333333);
        dREN = 1'b0;
        @(negedge CLK);

        // Reset during an instruction access
        iREN = 1'b1; iaddr = 32'h500; ramstate = 2'd1;
        @(negedge CLK);
        chk1("t32_ramREN_pre", ramREN, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        chk1("t32_strobes", ramREN | ramWEN, 1'b0);
        chk1("t32_hits", ihit | dhit, 1'b0);
        chk1("t32_memerr", memerr, 1'b0);
        chk("t32_ramaddr", ramaddr, 32'd0);
        chk("t32_ramstore", ramstore, 32'd0);
        chk("t32_iload", iload, 32'd0);
        chk("t32_dload", dload, 32'd0);
        RST = 1'b0; iREN = 1'b0; ramstate = 2'd0;
        repeat (3) @(negedge CLK);
        chk1("t32_no_late_ihit", ihit, 1'b0);

        // Randomised traffic against a memory model
        force_mode = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (iREN && ihit) iREN = 1'b0;
            if (!iREN && c < 2900 && $urandom_range(0, 2) == 0) begin
                iaddr = 32'h1000 + ($urandom_range(0, 255) << 2);
                iREN = 1'b1;
                iq.push_back(init_word(iaddr));
            end
            if ((dREN || dWEN) && dhit) begin dREN = 1'b0; dWEN = 1'b0; end
            if (!dREN && !dWEN && c < 2900 && $urandom_range(0, 2) == 0) begin
                a = 32'h8000 + ($urandom_range(0, 7) << 2);
                daddr = a;
                if ($urandom_range(0, 1) == 1) begin
                    dstore = $urandom;
                    dWEN = 1'b1;
                    model_mem[a] = dstore;
                    wq.push_back({a, dstore});
                    dq.push_back(dexp_t'{is_write: 1'b1, data: 32'd0});
                end else begin
                    dREN = 1'b1;
                    dq.push_back(dexp_t'{is_write: 1'b0,
                                         data: model_mem.exists(a) ? model_mem[a] : init_word(a)});
                end
            end
        end
        for (int c = 0; c < 300 && (iREN || dREN || dWEN); c++) begin
            @(negedge CLK);
            if (ihit) iREN = 1'b0;
            if (dhit) begin dREN = 1'b0; dWEN = 1'b0; end
        end
        chk1("rand_drained", iREN | dREN | dWEN, 1'b0);
        repeat (2) @(negedge CLK);
        chk("rand_iq_empty", 32'(iq.size()), 32'd0);
        chk("rand_dq_empty", 32'(dq.size()), 32'd0);
        chk("rand_wq_empty", 32'(wq.size()), 32'd0);
        chk1("rand_memerr", memerr, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4, giving the maximum consecutive data grants while an instruction request waits.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the maximum wait cycles per RAM access before abort.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
 CLK  in  1  clock; all state updates on rising edge
 RST  in  1  synchronous active-high reset
 iREN  in  1  instruction read request, held until ihit
 iaddr  in  32  instruction address
 dREN  in  1  data read request, held until dhit
 dWEN  in  1  data write request, held until dhit
 daddr  in  32  data address
 dstore  in  32  data write value
 ramload  in  32  RAM read data
 ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
 ihit  out  1  one-cycle instruction completion pulse
 iload  out  32  fetched instruction, valid while ihit
 dhit  out  1  one-cycle data completion pulse
 dload  out  32  loaded data, valid while dhit
 ramREN  out  1  RAM read strobe
 ramWEN  out  1  RAM write strobe
 ramaddr  out  32  RAM address
 ramstore  out  32  RAM write data
 memerr  out  1  sticky error flag

Function
REQ-004 The FSM SHALL have states IDLE, IACC, DACC and DONE.
REQ-005 In IDLE, on a pending data request (dREN|dWEN), the FSM SHALL go to DACC, unless iREN=1 and starve_cnt==STARVE_MAX, in which case it SHALL go to IACC.
REQ-006 In IDLE, with no pending data request and iREN=1, the FSM SHALL go to IACC; with no requests it SHALL stay in IDLE.
REQ-007 On entering IACC/DACC, the block SHALL register the address, store data and type (read/write).
REQ-008 While in IACC/DACC, RAM outputs SHALL be driven only from registered values; the request inputs SHALL be ignored.
REQ-009 If dREN and dWEN are both 1 at grant, the block SHALL perform a write and set memerr.
REQ-010 In IACC, the block SHALL drive ramREN=1, ramWEN=0 and ramaddr=latched iaddr.
REQ-011 In DACC, the block SHALL drive ramaddr=latched daddr, ramstore=latched dstore, and exactly one of ramREN/ramWEN per the latched type.
REQ-012 In IDLE and DONE, ramREN and ramWEN SHALL be 0.
REQ-013 In IACC/DACC, when ramstate==ACCESS, the block SHALL register ramload into iload/dload and go to DONE.
REQ-014 In DONE, the block SHALL assert exactly one of ihit/dhit for exactly one cycle, then return to IDLE.
REQ-015 DONE SHALL NOT re-sample requests, so a still-held request is not re-granted.
REQ-016 Minimum latency SHALL be: request seen in IDLE at cycle 0 -> RAM strobe at cycle 1 -> ACCESS at cycle 1 -> hit at cycle 2 -> next grant decision at cycle 3.
REQ-017 In IACC/DACC, ramstate==ERROR SHALL set memerr and return to IDLE with no hit; the held request is then retried.
REQ-018 A 4-bit wait counter SHALL clear on grant and increment each IACC/DACC cycle without ACCESS.
REQ-019 When the wait counter reaches TIMEOUT, the block SHALL set memerr and go to IDLE with no hit.
REQ-020 starve_cnt (3 bits) SHALL increment on each DACC grant made while iREN=1, saturating at STARVE_MAX.
REQ-021 starve_cnt SHALL clear on any IACC grant and on any IDLE cycle with iREN=0.
REQ-022 memerr SHALL stay set once set, clearing only on RST.
REQ-023 iload/dload SHALL hold their last value outside hit cycles.

Reset
REQ-024 When RST=1 at a clock edge, the block SHALL go to IDLE and clear ihit, dhit, ramREN, ramWEN, memerr, starve_cnt and the wait counter.
REQ-025 On that reset edge, the block SHALL clear ramaddr, ramstore, iload and dload to 0.
REQ-026 RST SHALL abort any in-flight access (RAM strobes low next cycle) and no hit for that access SHALL ever be issued.

Verification
REQ-027 The bench SHALL drive iREN=1, iaddr=0x40, ramstate=ACCESS immediately, ramload=0x8C010004 -> ramREN high at cycle 1, ihit=1 with iload=0x8C010004 at cycle 2 only.
REQ-028 The bench SHALL drive iREN and dWEN together (daddr=0x100, dstore=0xDEADBEEF) -> data write served first (ramWEN, ramstore=0xDEADBEEF), dhit, then IACC, ihit.
REQ-029 The bench SHALL hold iREN=1 and dREN=1 continuously with instant ACCESS -> grants in order D,D,D,D,I,D,...; the fifth grant is instruction.
REQ-030 The bench SHALL drive dREN=1 with ramstate=BUSY for 15 cycles -> memerr=1, no dhit, FSM in IDLE; memerr remains 1 until RST.
REQ-031 The bench SHALL drive ramstate=ERROR for one cycle during DACC, then ACCESS -> memerr=1, access retried, dhit after retry.
REQ-032 The bench SHALL assert RST during IACC with ramstate=BUSY -> next cycle ramREN=0, all outputs 0, no ihit.
